// File: rtl/mac_pe_db.sv
// Weight-stationary systolic MAC processing element with a double-buffered weight.
// A shadow weight loads through the column chain while the active weight keeps serving MACs.
module mac_pe_db #(
   parameter int ACT_W      = 8,
   parameter int WT_W       = 8,
   parameter int ACC_W      = 32,
   parameter bit SIGNED_ACT = 1'b0,
   parameter bit SATURATE   = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ACT_W-1:0] in_act,
   input  logic             in_act_valid,
   input  logic [ACC_W-1:0] in_psum,
   input  logic             in_psum_valid,
   input  logic [WT_W-1:0]  in_wt,
   input  logic             in_wt_valid,
   input  logic             in_swap,
   input  logic             ovf_clr,
   output logic [ACT_W-1:0] out_act,
   output logic             out_act_valid,
   output logic [ACC_W-1:0] out_psum,
   output logic             out_psum_valid,
   output logic [WT_W-1:0]  out_wt,
   output logic             out_wt_valid,
   output logic             out_swap,
   output logic             wt_ready,
   output logic             shadow_full,
   output logic             ovf
);

   localparam int PW = ACT_W + WT_W + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   generate
      if (ACC_W < PW) begin : g_width_check
         $error("mac_pe_db: ACC_W must be at least ACT_W+WT_W+1");
      end
   endgenerate

   logic [ACT_W-1:0] act_q, act_d;
   logic             act_valid_q, act_valid_d;
   logic             swap_q, swap_d;
   logic [WT_W-1:0]  wt_out_q, wt_out_d;
   logic             wt_out_valid_q, wt_out_valid_d;
   logic [WT_W-1:0]  shadow_q, shadow_d;
   logic             shadow_full_q, shadow_full_d;
   logic [WT_W-1:0]  active_q, active_d;
   logic             wt_ready_q, wt_ready_d;
   logic [ACC_W-1:0] psum_q, psum_d;
   logic             psum_valid_q, psum_valid_d;
   logic             ovf_q, ovf_d;

   logic [ACT_W:0]        a_ext;
   logic signed [PW-1:0]  a_px;
   logic signed [PW-1:0]  w_px;
   logic signed [PW-1:0]  prod;
   logic [ACC_W-1:0]      addend;
   logic [ACC_W:0]        sum;
   logic                  ovf_hit;
   logic [ACC_W-1:0]      mac_res;

   // Datapath: the product always fits in PW bits, so truncating the PW-wide multiply is exact.
   always_comb begin
      a_ext   = SIGNED_ACT ? {in_act[ACT_W-1], in_act} : {1'b0, in_act};
      a_px    = {{(PW-ACT_W-1){a_ext[ACT_W]}}, a_ext};
      w_px    = {{(PW-WT_W){active_q[WT_W-1]}}, active_q};
      prod    = a_px * w_px;
      addend  = in_psum_valid ? in_psum : '0;
      sum     = {addend[ACC_W-1], addend} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
      ovf_hit = sum[ACC_W] ^ sum[ACC_W-1];
      mac_res = sum[ACC_W-1:0];
      if (SATURATE && ovf_hit) begin
         mac_res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_comb begin
      act_d          = in_act;
      act_valid_d    = in_act_valid;
      swap_d         = in_swap;
      wt_out_d       = wt_out_q;
      wt_out_valid_d = 1'b0;
      shadow_d       = shadow_q;
      shadow_full_d  = shadow_full_q;
      active_d       = active_q;
      wt_ready_d     = wt_ready_q;
      psum_d         = psum_q;
      psum_valid_d   = in_act_valid;
      ovf_d          = ovf_q;

      // Swap reads the pre-shift shadow; a same-cycle shift re-fills it afterwards.
      if (in_swap) begin
         active_d      = shadow_q;
         wt_ready_d    = wt_ready_q | shadow_full_q;
         shadow_full_d = 1'b0;
      end
      if (in_wt_valid) begin
         wt_out_d       = shadow_q;
         wt_out_valid_d = 1'b1;
         shadow_d       = in_wt;
         shadow_full_d  = 1'b1;
      end

      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (in_act_valid) begin
         if (wt_ready_q) begin
            psum_d = mac_res;
            if (ovf_hit) begin
               ovf_d = 1'b1;
            end
         end else begin
            psum_d = addend;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_q          <= '0;
         act_valid_q    <= 1'b0;
         swap_q         <= 1'b0;
         wt_out_q       <= '0;
         wt_out_valid_q <= 1'b0;
         shadow_q       <= '0;
         shadow_full_q  <= 1'b0;
         active_q       <= '0;
         wt_ready_q     <= 1'b0;
         psum_q         <= '0;
         psum_valid_q   <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         act_q          <= act_d;
         act_valid_q    <= act_valid_d;
         swap_q         <= swap_d;
         wt_out_q       <= wt_out_d;
         wt_out_valid_q <= wt_out_valid_d;
         shadow_q       <= shadow_d;
         shadow_full_q  <= shadow_full_d;
         active_q       <= active_d;
         wt_ready_q     <= wt_ready_d;
         psum_q         <= psum_d;
         psum_valid_q   <= psum_valid_d;
         ovf_q          <= ovf_d;
      end
   end

   assign out_act        = act_q;
   assign out_act_valid  = act_valid_q;
   assign out_swap       = swap_q;
   assign out_wt         = wt_out_q;
   assign out_wt_valid   = wt_out_valid_q;
   assign out_psum       = psum_q;
   assign out_psum_valid = psum_valid_q;
   assign wt_ready       = wt_ready_q;
   assign shadow_full    = shadow_full_q;
   assign ovf            = ovf_q;

endmodule

// File: tb/tb_mac_pe_db.sv
// Directed bench for mac_pe_db: three instances (unsigned/saturate, signed/saturate,
// unsigned/wrap) share one input stream and are checked against hand-computed values.
module tb_mac_pe_db;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_act = '0;
   logic        in_act_valid = 1'b0;
   logic [31:0] in_psum = '0;
   logic        in_psum_valid = 1'b0;
   logic [7:0]  in_wt = '0;
   logic        in_wt_valid = 1'b0;
   logic        in_swap = 1'b0;
   logic        ovf_clr = 1'b0;

   logic [7:0]  u_act, s_act, w_act;
   logic        u_act_v, s_act_v, w_act_v;
   logic [31:0] u_psum, s_psum, w_psum;
   logic        u_psum_v, s_psum_v, w_psum_v;
   logic [7:0]  u_wt, s_wt, w_wt;
   logic        u_wt_v, s_wt_v, w_wt_v;
   logic        u_swap, s_swap, w_swap;
   logic        u_rdy, s_rdy, w_rdy;
   logic        u_full, s_full, w_full;
   logic        u_ovf, s_ovf, w_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mac_pe_db #(.ACT_W(8), .WT_W(8), .ACC_W(32), .SIGNED_ACT(1'b0), .SATURATE(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_act(in_act), .in_act_valid(in_act_valid),
      .in_psum(in_psum), .in_psum_valid(in_psum_valid), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
      .in_swap(in_swap), .ovf_clr(ovf_clr), .out_act(u_act), .out_act_valid(u_act_v),
      .out_psum(u_psum), .out_psum_valid(u_psum_v), .out_wt(u_wt), .out_wt_valid(u_wt_v),
      .out_swap(u_swap), .wt_ready(u_rdy), .shadow_full(u_full), .ovf(u_ovf));

   mac_pe_db #(.ACT_W(8), .WT_W(8), .ACC_W(32), .SIGNED_ACT(1'b1), .SATURATE(1'b1)) s_dut (
      .clk(clk), .reset_n(reset_n), .in_act(in_act), .in_act_valid(in_act_valid),
      .in_psum(in_psum), .in_psum_valid(in_psum_valid), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
      .in_swap(in_swap), .ovf_clr(ovf_clr), .out_act(s_act), .out_act_valid(s_act_v),
      .out_psum(s_psum), .out_psum_valid(s_psum_v), .out_wt(s_wt), .out_wt_valid(s_wt_v),
      .out_swap(s_swap), .wt_ready(s_rdy), .shadow_full(s_full), .ovf(s_ovf));

   mac_pe_db #(.ACT_W(8), .WT_W(8), .ACC_W(32), .SIGNED_ACT(1'b0), .SATURATE(1'b0)) w_dut (
      .clk(clk), .reset_n(reset_n), .in_act(in_act), .in_act_valid(in_act_valid),
      .in_psum(in_psum), .in_psum_valid(in_psum_valid), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
      .in_swap(in_swap), .ovf_clr(ovf_clr), .out_act(w_act), .out_act_valid(w_act_v),
      .out_psum(w_psum), .out_psum_valid(w_psum_v), .out_wt(w_wt), .out_wt_valid(w_wt_v),
      .out_swap(w_swap), .wt_ready(w_rdy), .shadow_full(w_full), .ovf(w_ovf));

   typedef struct {
      logic [7:0]  act;
      logic        act_v;
      logic [31:0] psum;
      logic        psum_v;
      logic [31:0] exp_u;
      logic [31:0] exp_s;
      logic        exp_v;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_act = '0; in_act_valid = 1'b0; in_psum = '0; in_psum_valid = 1'b0;
      in_wt = '0; in_wt_valid = 1'b0; in_swap = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic load_weight(input logic [7:0] w);
      idle_inputs();
      in_wt = w; in_wt_valid = 1'b1;
      step();
      idle_inputs();
      in_swap = 1'b1;
      step();
      idle_inputs();
   endtask

   initial begin
      // Weight -3 loaded in every instance; products in hand-computed decimal.
      vecs[0] = '{8'd200, 1'b1, 32'd1000,  1'b1, 32'd400,      32'd1168,    1'b1};
      vecs[1] = '{8'd0,   1'b1, 32'd5,     1'b1, 32'd5,        32'd5,       1'b1};
      vecs[2] = '{8'd255, 1'b1, 32'd0,     1'b1, -32'sd765,    32'd3,       1'b1};
      vecs[3] = '{8'd1,   1'b1, -32'sd10,  1'b1, -32'sd13,     -32'sd13,    1'b1};
      vecs[4] = '{8'd7,   1'b0, 32'd99,    1'b1, -32'sd13,     -32'sd13,    1'b0};
      vecs[5] = '{8'd100, 1'b1, 32'd300,   1'b1, 32'd0,        -32'sd300+32'sd300, 1'b1};
      vecs[6] = '{8'hC8,  1'b1, 32'd999,   1'b0, -32'sd600,    32'd168,     1'b1};

      idle_inputs();
      #12;
      chk("rst_psum", u_psum, 32'd0);
      chk("rst_flags", {u_psum_v, u_act_v, u_wt_v, u_swap, u_rdy, u_full, u_ovf}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // Pass-through before any weight is loaded.
      in_act = 8'd50; in_act_valid = 1'b1; in_psum = 32'd77; in_psum_valid = 1'b1;
      step();
      chk("unloaded_psum", u_psum, 32'd77);
      chk("unloaded_ovf", {31'd0, u_ovf}, 32'd0);
      chk("unloaded_valid", {31'd0, u_psum_v}, 32'd1);

      idle_inputs();
      in_wt = 8'hFD; in_wt_valid = 1'b1;
      step();
      chk("load_full", {31'd0, u_full}, 32'd1);
      chk("load_ready", {31'd0, u_rdy}, 32'd0);
      chk("load_wt_valid", {31'd0, u_wt_v}, 32'd1);
      idle_inputs();
      in_swap = 1'b1;
      step();
      chk("swap_ready", {31'd0, u_rdy}, 32'd1);
      chk("swap_full", {31'd0, u_full}, 32'd0);
      chk("swap_token", {31'd0, u_swap}, 32'd1);
      chk("wt_valid_drop", {31'd0, u_wt_v}, 32'd0);
      idle_inputs();
      step();
      chk("swap_token_drop", {31'd0, u_swap}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         in_act = vecs[i].act; in_act_valid = vecs[i].act_v;
         in_psum = vecs[i].psum; in_psum_valid = vecs[i].psum_v;
         step();
         chk($sformatf("vec%0d_unsigned", i), u_psum, vecs[i].exp_u);
         chk($sformatf("vec%0d_signed", i), s_psum, vecs[i].exp_s);
         chk($sformatf("vec%0d_wrap", i), w_psum, vecs[i].exp_u);
         chk($sformatf("vec%0d_valid", i), {31'd0, u_psum_v}, {31'd0, vecs[i].exp_v});
         if (vecs[i].act_v) chk($sformatf("vec%0d_act", i), {24'd0, u_act}, {24'd0, vecs[i].act});
      end
      chk("no_ovf_yet", {29'd0, u_ovf, s_ovf, w_ovf}, 32'd0);

      // Saturation / wrap with weight 127.
      load_weight(8'd127);
      in_act = 8'd255; in_act_valid = 1'b1; in_psum = 32'h7FFF_FFF0; in_psum_valid = 1'b1;
      step();
      chk("sat_pos", u_psum, 32'h7FFF_FFFF);
      chk("wrap_pos", w_psum, 32'h8000_7E71);
      chk("signed_nosat", s_psum, 32'h7FFF_FF71);
      chk("ovf_set", {29'd0, u_ovf, s_ovf, w_ovf}, 32'b101);
      idle_inputs();
      step();
      chk("ovf_sticky", {31'd0, u_ovf}, 32'd1);
      in_act = 8'd255; in_act_valid = 1'b1; in_psum = 32'h8000_0010; in_psum_valid = 1'b1;
      step();
      chk("sat_neg", s_psum, 32'h8000_0000);
      chk("neg_unsigned", u_psum, 32'h8000_7E91);
      chk("neg_signed_ovf", {31'd0, s_ovf}, 32'd1);
      idle_inputs();
      ovf_clr = 1'b1;
      step();
      chk("ovf_clr", {29'd0, u_ovf, s_ovf, w_ovf}, 32'd0);
      in_act = 8'd255; in_act_valid = 1'b1; in_psum = 32'h7FFF_FFF0; in_psum_valid = 1'b1;
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", {31'd0, u_ovf}, 32'd1);
      idle_inputs();
      ovf_clr = 1'b1;
      step();
      idle_inputs();

      // Double buffer: active 2, shift 5 while streaming, swap mid-stream.
      load_weight(8'd2);
      in_act = 8'd10; in_act_valid = 1'b1; in_psum = 32'd1000; in_psum_valid = 1'b1;
      in_wt = 8'd5; in_wt_valid = 1'b1;
      step();
      chk("db_pre", u_psum, 32'd1020);
      chk("db_chain_out", {24'd0, u_wt}, 32'd2);
      in_wt_valid = 1'b0; in_swap = 1'b1;
      step();
      chk("db_swap_cycle", u_psum, 32'd1020);
      chk("db_swap_valid", {31'd0, u_psum_v}, 32'd1);
      in_swap = 1'b0;
      step();
      chk("db_new_weight", u_psum, 32'd1050);
      chk("db_new_valid", {31'd0, u_psum_v}, 32'd1);

      // Same-cycle swap and shift: active takes pre-shift shadow (9), shadow refilled.
      idle_inputs();
      in_wt = 8'd9; in_wt_valid = 1'b1;
      step();
      in_wt = 8'd4; in_swap = 1'b1;
      step();
      chk("same_cycle_full", {31'd0, u_full}, 32'd1);
      chk("same_cycle_chain", {24'd0, u_wt}, 32'd9);
      idle_inputs();
      in_act = 8'd1; in_act_valid = 1'b1;
      step();
      chk("same_cycle_active", u_psum, 32'd9);

      // Asynchronous reset mid-stream.
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_psum", u_psum, 32'd0);
      chk("async_flags", {u_psum_v, u_act_v, u_rdy, u_full, u_ovf}, 32'd0);
      chk("async_act", {24'd0, u_act}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      in_act = 8'd10; in_act_valid = 1'b1; in_psum = 32'd33; in_psum_valid = 1'b1;
      step();
      chk("post_rst_ready", {31'd0, u_rdy}, 32'd0);
      chk("post_rst_passthru", u_psum, 32'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
